// File: rtl/mine_placer.sv
// Board-setup sequencer: clears the grid, scatters NUM_MINES mines (code 10) away from the
// safe cell using a Galois LFSR, then strobes the RAM's number port for every non-mine cell.
module mine_placer #(
  parameter int          GRID_W        = 5,
  parameter int          GRID_H        = 5,
  parameter int          CELLS         = GRID_W * GRID_H,
  parameter int          CELL_BITS     = 5,
  parameter int          NUM_MINES     = 5,
  parameter int          ADDRESS_WIDTH = 12,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] safeCell,
  output logic                     busy,
  output logic                     done,
  output logic                     wEn,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    wData,
  input  logic [DATA_WIDTH-1:0]    rData,
  output logic [31:0]              checkID,
  output logic                     nowCheck,
  output logic [CELL_BITS:0]       mineCount
);

  if (NUM_MINES < 1 || NUM_MINES > CELLS - 1) begin : g_bad_mines
    $error("mine_placer: NUM_MINES must lie in 1..CELLS-1");
  end
  if (CELLS > (1 << CELL_BITS)) begin : g_bad_cells
    $error("mine_placer: CELLS exceeds the LFSR candidate range");
  end

  localparam logic [15:0]           SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [15:0]           TAPS     = 16'hB400;
  localparam logic [DATA_WIDTH-1:0] MINE     = DATA_WIDTH'(10);
  localparam logic [CELL_BITS-1:0]  LAST     = CELL_BITS'(CELLS - 1);
  localparam logic [CELL_BITS:0]    NM       = (CELL_BITS + 1)'(NUM_MINES);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PICK, S_TEST, S_WRITE, S_NREAD, S_NUMB, S_DONE
  } state_t;

  state_t                   state, state_d;
  logic [CELL_BITS-1:0]     idx, idx_d, cand, cand_d;
  logic [ADDRESS_WIDTH-1:0] safe, safe_d;
  logic [15:0]              lfsr, lfsr_d, lfsr_next;
  logic                     busy_d, done_d, wen_d, now_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]    wdata_d;
  logic [31:0]              check_d;
  logic [CELL_BITS:0]       mines_d;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0);

  // Outputs are computed one state ahead and registered, so a state's RAM access is
  // visible during the following cycle and the RAM's negedge write sees stable values.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cand_d  = cand;
    safe_d  = safe;
    lfsr_d  = lfsr;
    busy_d  = busy;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    now_d   = 1'b0;
    addr_d  = addr;
    wdata_d = wData;
    check_d = checkID;
    mines_d = mineCount;
    case (state)
      S_IDLE: begin
        if (start) begin
          safe_d  = safeCell;
          idx_d   = '0;
          mines_d = '0;
          busy_d  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wen_d   = 1'b1;
        addr_d  = ADDRESS_WIDTH'(idx);
        wdata_d = '0;
        idx_d   = idx + 1'b1;
        if (idx == LAST) state_d = S_PICK;
      end
      S_PICK: begin
        lfsr_d  = lfsr_next;
        cand_d  = lfsr_next[CELL_BITS-1:0];
        addr_d  = ADDRESS_WIDTH'(lfsr_next[CELL_BITS-1:0]);
        state_d = S_TEST;
      end
      S_TEST: begin
        // An out-of-range safe cell never equals an in-range candidate, so nothing is excluded.
        if (int'(cand) >= CELLS || ADDRESS_WIDTH'(cand) == safe || rData == MINE)
          state_d = S_PICK;
        else
          state_d = S_WRITE;
      end
      S_WRITE: begin
        wen_d   = 1'b1;
        addr_d  = ADDRESS_WIDTH'(cand);
        wdata_d = MINE;
        mines_d = mineCount + 1'b1;
        if ((mineCount + 1'b1) == NM) begin
          idx_d   = '0;
          state_d = S_NREAD;
        end else begin
          state_d = S_PICK;
        end
      end
      S_NREAD: begin
        addr_d  = ADDRESS_WIDTH'(idx);
        state_d = S_NUMB;
      end
      S_NUMB: begin
        if (rData != MINE) begin
          now_d   = 1'b1;
          check_d = 32'(idx);
        end
        idx_d   = idx + 1'b1;
        state_d = (idx == LAST) ? S_DONE : S_NREAD;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      cand      <= '0;
      safe      <= '0;
      lfsr      <= SEED_EFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      wEn       <= 1'b0;
      addr      <= '0;
      wData     <= '0;
      checkID   <= '0;
      nowCheck  <= 1'b0;
      mineCount <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cand      <= cand_d;
      safe      <= safe_d;
      lfsr      <= lfsr_d;
      busy      <= busy_d;
      done      <= done_d;
      wEn       <= wen_d;
      addr      <= addr_d;
      wData     <= wdata_d;
      checkID   <= check_d;
      nowCheck  <= now_d;
      mineCount <= mines_d;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: three instances (default, 24 mines, SEED=0) each with a board RAM model
// and a scoreboard of expected number-strobe cell IDs.
module tb_mine_placer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [3];
  logic [11:0] safeCell [3];
  logic        busy [3], done [3], wEn [3], nowCheck [3];
  logic [11:0] addr [3];
  logic [31:0] wData [3], rData [3], checkID [3];
  logic [5:0]  mineCount [3];

  int          errors = 0, checks = 0;
  logic [31:0] board [3][32];
  int          expq [3][$];
  int          npulse [3], ndone [3], overlap [3];
  bit          armed [3];
  logic [31:0] layout0;

  always #5 clk = ~clk;

  mine_placer u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .safeCell(safeCell[0]),
    .busy(busy[0]), .done(done[0]), .wEn(wEn[0]), .addr(addr[0]), .wData(wData[0]),
    .rData(rData[0]), .checkID(checkID[0]), .nowCheck(nowCheck[0]), .mineCount(mineCount[0]));
  mine_placer #(.NUM_MINES(24)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]),
    .safeCell(safeCell[1]), .busy(busy[1]), .done(done[1]), .wEn(wEn[1]), .addr(addr[1]),
    .wData(wData[1]), .rData(rData[1]), .checkID(checkID[1]), .nowCheck(nowCheck[1]),
    .mineCount(mineCount[1]));
  mine_placer #(.SEED(16'h0)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]),
    .safeCell(safeCell[2]), .busy(busy[2]), .done(done[2]), .wEn(wEn[2]), .addr(addr[2]),
    .wData(wData[2]), .rData(rData[2]), .checkID(checkID[2]), .nowCheck(nowCheck[2]),
    .mineCount(mineCount[2]));

  function automatic int nm(int i);
    return (i == 1) ? 24 : 5;
  endfunction

  function automatic int nbr(int i, int c);
    int n = 0;
    int r = c / 5;
    int col = c % 5;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 5 && col + dc >= 0 && col + dc < 5)
          if (board[i][(r + dr) * 5 + col + dc] == 32'd10) n++;
    return n;
  endfunction

  function automatic logic [31:0] layout(int i);
    logic [31:0] m = '0;
    for (int c = 0; c < 25; c++) m[c] = (board[i][c] == 32'd10);
    return m;
  endfunction

  function automatic int mines_in(int i);
    int n = 0;
    for (int c = 0; c < 25; c++) if (board[i][c] == 32'd10) n++;
    return n;
  endfunction

  always_comb
    for (int i = 0; i < 3; i++)
      rData[i] = (addr[i] < 12'd32) ? board[i][addr[i][4:0]] : 32'd0;

  // RAM model (negedge writes) plus monitor; the expected strobe sequence is queued once all
  // mines are in, and each nowCheck pops and compares one entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        armed[i] = 1'b0;
        expq[i].delete();
      end else begin
        if (wEn[i] && nowCheck[i]) overlap[i]++;
        if (nowCheck[i]) begin
          npulse[i]++;
          checks++;
          if (expq[i].size() == 0) begin
            errors++;
            $display("FAIL strobe_seq inst%0d: unexpected nowCheck checkID=%0d", i, checkID[i]);
          end else begin
            int e;
            e = expq[i].pop_front();
            if (checkID[i] !== 32'(e)) begin
              errors++;
              $display("FAIL strobe_seq inst%0d: checkID=%0d expected %0d", i, checkID[i], e);
            end
          end
        end
        if (done[i]) ndone[i]++;
        if (wEn[i] && addr[i] < 12'd32) board[i][addr[i][4:0]] = wData[i];
        if (nowCheck[i] && checkID[i] < 32'd25) board[i][checkID[i][4:0]] = 32'(nbr(i, int'(checkID[i])));
        if (busy[i] && !armed[i] && int'(mineCount[i]) == nm(i)) begin
          armed[i] = 1'b1;
          for (int c = 0; c < 25; c++) if (board[i][c] != 32'd10) expq[i].push_back(c);
        end
        if (done[i]) armed[i] = 1'b0;
      end
    end
  end

  task automatic run_board(input int i, input logic [11:0] sc, output bit ok);
    npulse[i] = 0; ndone[i] = 0; overlap[i] = 0;
    @(negedge clk); safeCell[i] = sc; start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (done[i]) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; safeCell[i] = '0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], wEn[i], addr[i], wData[i], checkID[i], nowCheck[i], mineCount[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: busy=%b done=%b wEn=%b addr=%0d mineCount=%0d required all 0",
                 i, busy[i], done[i], wEn[i], addr[i], mineCount[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_board;
    bit ok;
    run_board(0, 12'd12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL board_timeout: done never seen"); end
    checks++; if (ndone[0] != 1) begin errors++; $display("FAIL board_done_pulses: got %0d required 1", ndone[0]); end
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL board_done_width: done=%b required 0", done[0]); end
    checks++; if (mines_in(0) != 5) begin errors++; $display("FAIL board_mines: got %0d required 5", mines_in(0)); end
    checks++; if (board[0][12] == 32'd10) begin errors++; $display("FAIL board_safe: cell 12=%0d required !=10", board[0][12]); end
    for (int c = 0; c < 25; c++)
      if (board[0][c] != 32'd10) begin
        checks++;
        if (board[0][c] !== 32'(nbr(0, c))) begin
          errors++; $display("FAIL board_count cell%0d: got %0d required %0d", c, board[0][c], nbr(0, c));
        end
      end
    checks++; if (mineCount[0] !== 6'd5) begin errors++; $display("FAIL board_minecount: got %0d required 5", mineCount[0]); end
    checks++; if (npulse[0] != 20) begin errors++; $display("FAIL board_strobes: got %0d required 20", npulse[0]); end
    checks++; if (expq[0].size() != 0) begin errors++; $display("FAIL board_queue: %0d left required 0", expq[0].size()); end
    checks++; if (overlap[0] != 0) begin errors++; $display("FAIL board_overlap: got %0d required 0", overlap[0]); end
    layout0 = layout(0);
  endtask

  task automatic test_back_to_back;
    bit ok = 1'b0, pick_hit = 1'b0;
    int busy_low = 0;
    npulse[0] = 0; ndone[0] = 0; overlap[0] = 0;
    @(negedge clk); safeCell[0] = 12'd12; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (done[0]) begin ok = 1'b1; break; end
      if (!busy[0]) busy_low++;
      if (k == 3) begin safeCell[0] = 12'd5; start[0] = 1'b1; end
      if (k > 26 && !pick_hit && !wEn[0]) begin pick_hit = 1'b1; start[0] = 1'b1; end
    end
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: done never seen"); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL b2b_busy: low for %0d cycles required 0", busy_low); end
    checks++; if (ndone[0] != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d required 1", ndone[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", busy[0]); end
    checks++; if (board[0][12] == 32'd10) begin errors++; $display("FAIL b2b_safe: cell 12 holds a mine"); end
    checks++; if (mines_in(0) != 5) begin errors++; $display("FAIL b2b_mines: got %0d required 5", mines_in(0)); end
    checks++; if (layout(0) == layout0) begin errors++; $display("FAIL b2b_layout: %h repeats first board %h", layout(0), layout0); end
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    @(negedge clk); safeCell[0] = 12'd12; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (wEn[0] && addr[0] == 12'd7) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach: idx 7 of clear never seen"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[0], wEn[0], addr[0], wData[0], nowCheck[0], mineCount[0]} !== '0) begin
      errors++; $display("FAIL mid_reset_async: busy=%b wEn=%b addr=%0d required 0", busy[0], wEn[0], addr[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy[0], done[0], wEn[0], addr[0], nowCheck[0]} !== '0) begin
      errors++; $display("FAIL mid_reset_hold: busy=%b wEn=%b addr=%0d required 0", busy[0], wEn[0], addr[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    run_board(0, 12'd12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_restart_timeout: done never seen"); end
    checks++; if (layout(0) !== layout0) begin errors++; $display("FAIL mid_restart_layout: %h required %h", layout(0), layout0); end
    checks++; if (npulse[0] != 20) begin errors++; $display("FAIL mid_restart_strobes: got %0d required 20", npulse[0]); end
    for (int c = 0; c < 25; c++)
      if (board[0][c] != 32'd10) begin
        checks++;
        if (board[0][c] !== 32'(nbr(0, c))) begin
          errors++; $display("FAIL mid_restart_count cell%0d: got %0d required %0d", c, board[0][c], nbr(0, c));
        end
      end
  endtask

  task automatic test_many;
    bit ok;
    int n = 0;
    run_board(1, 12'd0, ok);
    for (int c = 1; c < 25; c++) if (board[1][c] == 32'd10) n++;
    checks++; if (!ok) begin errors++; $display("FAIL many_timeout: done never seen"); end
    checks++; if (n != 24) begin errors++; $display("FAIL many_mines: got %0d required 24", n); end
    checks++; if (board[1][0] !== 32'd3) begin errors++; $display("FAIL many_cell0: got %0d required 3", board[1][0]); end
    checks++; if (mineCount[1] !== 6'd24) begin errors++; $display("FAIL many_minecount: got %0d required 24", mineCount[1]); end
    checks++; if (npulse[1] != 1) begin errors++; $display("FAIL many_strobes: got %0d required 1", npulse[1]); end
    checks++; if (overlap[1] != 0) begin errors++; $display("FAIL many_overlap: got %0d required 0", overlap[1]); end
  endtask

  task automatic test_seed0;
    bit ok;
    run_board(2, 12'd12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seed0_timeout: done never seen"); end
    checks++; if (layout(2) !== layout0) begin errors++; $display("FAIL seed0_layout: %h required %h", layout(2), layout0); end
    checks++; if (npulse[2] != 20) begin errors++; $display("FAIL seed0_strobes: got %0d required 20", npulse[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      npulse[i] = 0; ndone[i] = 0; overlap[i] = 0; armed[i] = 1'b0;
      for (int c = 0; c < 32; c++) board[i][c] = '0;
    end
    test_reset();
    test_board();
    test_back_to_back();
    test_reset_mid();
    test_many();
    test_seed0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
